// File: rtl/data_uncache_wr_pkg.sv
// ============================================================================
// data_uncache_wr_pkg : shared AXI encodings, uncached IDs and bridge states
// Revision: 1.0
// ============================================================================
`default_nettype none

package data_uncache_wr_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] UNCACHE_AWID   = 4'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RESP = 2'd2
    } wr_state_t;

endpackage

`default_nettype wire

// File: rtl/data_uncache_wr.sv
// ============================================================================
// data_uncache_wr : uncached store bridge, sram-like write -> single-beat AXI
// Revision: 1.0
// ============================================================================
`default_nettype none

module data_uncache_wr
    import data_uncache_wr_pkg::*;
#(
    parameter logic [3:0] AWID = UNCACHE_AWID
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        wr_req,
    input  logic [31:0] wr_addr,
    input  logic [1:0]  wr_size,
    input  logic [3:0]  wr_wstrb,
    input  logic [31:0] wr_wdata,
    output logic        wr_addr_ok,
    output logic        wr_data_ok,
    output logic        wr_err,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic [3:0]  awqos,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    wr_state_t   state;
    logic        aw_done;
    logic        w_done;
    logic [31:0] addr_r;
    logic [1:0]  size_r;
    logic [3:0]  wstrb_r;
    logic [31:0] wdata_r;

    logic aw_fire;
    logic w_fire;
    logic aw_complete;
    logic w_complete;
    logic unused_bresp;

    // Only SLVERR/DECERR (bit 1) count as failures; EXOKAY is never requested.
    assign unused_bresp = bresp[0];

    assign aw_fire     = awvalid & awready;
    assign w_fire      = wvalid & wready;
    assign aw_complete = aw_done | aw_fire;
    assign w_complete  = w_done | w_fire;

    assign bready     = (state == ST_RESP);
    assign wr_data_ok = (state == ST_RESP) & bvalid;
    assign wr_err     = wr_data_ok & (bresp[1] | (bid != AWID));
    assign wr_addr_ok = wr_req & ((state == ST_IDLE) | wr_data_ok);

    assign awid    = AWID;
    assign awaddr  = addr_r;
    assign awlen   = 4'd0;
    assign awsize  = {1'b0, size_r};
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awqos   = 4'd0;

    assign wid   = AWID;
    assign wdata = wdata_r;
    assign wstrb = wstrb_r;
    assign wlast = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            addr_r  <= 32'd0;
            size_r  <= 2'd0;
            wstrb_r <= 4'd0;
            wdata_r <= 32'd0;
        end else begin
            if (wr_addr_ok) begin
                addr_r  <= wr_addr;
                size_r  <= wr_size;
                wstrb_r <= wr_wstrb;
                wdata_r <= wr_wdata;
            end

            case (state)
                ST_IDLE: begin
                    if (wr_addr_ok) begin
                        state   <= ST_SEND;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (aw_fire) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_fire) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    // Both channels may finish in either order or together.
                    if (aw_complete && w_complete) begin
                        state   <= ST_RESP;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (bvalid) begin
                        if (wr_req) begin
                            state   <= ST_SEND;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    awvalid <= 1'b0;
                    wvalid  <= 1'b0;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_uncache_wr.sv
// ============================================================================
// tb_data_uncache_wr : scenario and randomized checks of the uncached store bridge
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_data_uncache_wr;

    localparam logic [3:0] EXP_AWID = 4'd1;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [1:0]  wr_size;
    logic [3:0]  wr_wstrb;
    logic [31:0] wr_wdata;
    logic        wr_addr_ok;
    logic        wr_data_ok;
    logic        wr_err;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic [3:0]  awqos;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_uncache_wr #(.AWID(EXP_AWID)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size),
        .wr_wstrb(wr_wstrb), .wr_wdata(wr_wdata),
        .wr_addr_ok(wr_addr_ok), .wr_data_ok(wr_data_ok), .wr_err(wr_err),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awqos(awqos), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_req = 1'b0; wr_addr = 32'd0; wr_size = 2'd0;
        wr_wstrb = 4'd0; wr_wdata = 32'd0; awready = 1'b0; wready = 1'b0;
        bid = 4'd0; bresp = 2'd0; bvalid = 1'b0;
        tick(); tick();
        settle();
        checks++;
        if ({awvalid, wvalid, bready, wr_data_ok, wr_addr_ok} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: aw/w/b/dok/aok=%b want 00000",
                     {awvalid, wvalid, bready, wr_data_ok, wr_addr_ok});
        end
        checks++;
        if ({awid, wid, awlen, awburst, awlock, awcache, awprot, awqos, wlast} !==
            {EXP_AWID, EXP_AWID, 4'd0, 2'b01, 2'b00, 4'd0, 3'd0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_constants: awid=%0d wid=%0d awlen=%0d awburst=%0d wlast=%b",
                     awid, wid, awlen, awburst, wlast);
        end
        rst = 1'b0;
        tick();
    endtask

    // One complete write from IDLE; expected values come straight from the arguments.
    task automatic run_write(input logic [31:0] a, input logic [1:0] sz,
                             input logic [3:0] st, input logic [31:0] d,
                             input int aw_dly, input int w_dly, input int b_dly,
                             input logic [3:0] b_id, input logic [1:0] b_resp);
        int  cyc;
        bit  aw_hs;
        bit  w_hs;
        logic exp_err;
        exp_err = b_resp[1] || (b_id != EXP_AWID);
        aw_hs = 0; w_hs = 0; cyc = 0;

        wr_req = 1'b1; wr_addr = a; wr_size = sz; wr_wstrb = st; wr_wdata = d;
        settle();
        checks++;
        if (wr_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL accept: wr_addr_ok=%b want 1", wr_addr_ok);
        end
        tick();
        // Scramble the request lines: the bridge must be using its latched copy.
        wr_req = 1'b0; wr_addr = $urandom; wr_wdata = $urandom;
        wr_wstrb = 4'($urandom); wr_size = 2'($urandom);
        settle();
        checks++;
        if ({awvalid, wvalid} !== 2'b11) begin
            errors++;
            $display("FAIL valid_latency: awvalid=%b wvalid=%b want 1 1", awvalid, wvalid);
        end

        while (!(aw_hs && w_hs) && cyc < 40) begin
            awready = (cyc >= aw_dly);
            wready  = (cyc >= w_dly);
            settle();
            checks++;
            if (awvalid !== !aw_hs || wvalid !== !w_hs || bready !== 1'b0) begin
                errors++;
                $display("FAIL send_valids: awvalid=%b wvalid=%b bready=%b want %b %b 0",
                         awvalid, wvalid, bready, !aw_hs, !w_hs);
            end
            if (awvalid === 1'b1) begin
                checks++;
                if (awaddr !== a || awsize !== {1'b0, sz} || awlen !== 4'd0 ||
                    awburst !== 2'b01 || awid !== EXP_AWID) begin
                    errors++;
                    $display("FAIL aw_payload: awaddr=%h awsize=%0d awlen=%0d want %h %0d 0",
                             awaddr, awsize, awlen, a, sz);
                end
                if (awready) aw_hs = 1;
            end
            if (wvalid === 1'b1) begin
                checks++;
                if (wdata !== d || wstrb !== st || wlast !== 1'b1 || wid !== EXP_AWID) begin
                    errors++;
                    $display("FAIL w_payload: wdata=%h wstrb=%h wlast=%b want %h %h 1",
                             wdata, wstrb, wlast, d, st);
                end
                if (wready) w_hs = 1;
            end
            tick();
            cyc++;
        end
        awready = 1'b0; wready = 1'b0;
        if (!(aw_hs && w_hs)) begin
            checks++; errors++;
            $display("FAIL send_timeout: aw_hs=%0d w_hs=%0d want 1 1", aw_hs, w_hs);
        end

        settle();
        checks++;
        if (bready !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0) begin
            errors++;
            $display("FAIL resp_entry: bready=%b awvalid=%b wvalid=%b want 1 0 0",
                     bready, awvalid, wvalid);
        end
        for (int i = 0; i < b_dly; i++) begin
            checks++;
            if (wr_data_ok !== 1'b0 || bready !== 1'b1) begin
                errors++;
                $display("FAIL resp_wait: wr_data_ok=%b bready=%b want 0 1", wr_data_ok, bready);
            end
            tick(); settle();
        end
        bvalid = 1'b1; bid = b_id; bresp = b_resp;
        settle();
        checks++;
        if (wr_data_ok !== 1'b1 || wr_err !== exp_err || wr_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL complete: wr_data_ok=%b wr_err=%b wr_addr_ok=%b want 1 %b 0",
                     wr_data_ok, wr_err, wr_addr_ok, exp_err);
        end
        tick();
        bvalid = 1'b0; bid = 4'd0; bresp = 2'd0;
        settle();
        checks++;
        if (bready !== 1'b0 || wr_data_ok !== 1'b0 || awvalid !== 1'b0) begin
            errors++;
            $display("FAIL back_idle: bready=%b wr_data_ok=%b awvalid=%b want 0 0 0",
                     bready, wr_data_ok, awvalid);
        end
        tick();
    endtask

    task automatic test_word_store();
        run_write(32'h1FD0_03F8, 2'd2, 4'hF, 32'hDEAD_BEEF, 0, 0, 1, EXP_AWID, 2'b00);
    endtask

    task automatic test_split_handshake();
        run_write(32'h1FD0_0100, 2'd2, 4'hF, 32'hCAFE_F00D, 3, 0, 0, EXP_AWID, 2'b00);
        run_write(32'h1FD0_0104, 2'd1, 4'h3, 32'h0000_A5A5, 0, 2, 2, EXP_AWID, 2'b00);
    endtask

    task automatic test_back_to_back();
        awready = 1'b1; wready = 1'b1;
        wr_req = 1'b1; wr_addr = 32'h1FD0_03F8; wr_size = 2'd2;
        wr_wstrb = 4'hF; wr_wdata = 32'hDEAD_BEEF;
        settle();
        checks++;
        if (wr_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_accept: wr_addr_ok=%b want 1", wr_addr_ok);
        end
        tick();
        wr_addr = 32'h1FD0_03FC; wr_wdata = 32'h1234_5678;
        settle();
        checks++;
        if (wr_addr_ok !== 1'b0 || awaddr !== 32'h1FD0_03F8) begin
            errors++;
            $display("FAIL b2b_hold_send: wr_addr_ok=%b awaddr=%h want 0 1fd003f8",
                     wr_addr_ok, awaddr);
        end
        tick(); settle();
        checks++;
        if (wr_addr_ok !== 1'b0 || bready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hold_resp: wr_addr_ok=%b bready=%b want 0 1", wr_addr_ok, bready);
        end
        tick();
        bvalid = 1'b1; bid = EXP_AWID; bresp = 2'b00;
        settle();
        checks++;
        if (wr_addr_ok !== 1'b1 || wr_data_ok !== 1'b1 || wr_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: wr_addr_ok=%b wr_data_ok=%b wr_err=%b want 1 1 0",
                     wr_addr_ok, wr_data_ok, wr_err);
        end
        tick();
        bvalid = 1'b0; wr_req = 1'b0;
        settle();
        checks++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 32'h1FD0_03FC ||
            wdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL b2b_second: awvalid=%b awaddr=%h wdata=%h want 1 1fd003fc 12345678",
                     awvalid, awaddr, wdata);
        end
        tick(); settle();
        checks++;
        if (bready !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_resp: bready=%b awvalid=%b want 1 0", bready, awvalid);
        end
        bvalid = 1'b1;
        settle();
        checks++;
        if (wr_data_ok !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_done: wr_data_ok=%b want 1", wr_data_ok);
        end
        tick();
        bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
        tick();
    endtask

    task automatic test_byte_error();
        run_write(32'h1FE0_0003, 2'd0, 4'h8, 32'h7700_0000, 0, 0, 0, EXP_AWID, 2'b10);
        run_write(32'h1FE0_0004, 2'd2, 4'hF, 32'h0BAD_CAFE, 1, 1, 0, 4'd5, 2'b00);
        run_write(32'h1FE0_0008, 2'd2, 4'hF, 32'h600D_600D, 0, 0, 0, EXP_AWID, 2'b00);
    endtask

    task automatic test_reset_mid_send();
        awready = 1'b0; wready = 1'b0;
        wr_req = 1'b1; wr_addr = 32'h1FD0_0200; wr_size = 2'd2;
        wr_wstrb = 4'hF; wr_wdata = 32'h5555_AAAA;
        tick();
        wr_req = 1'b0;
        settle();
        checks++;
        if (awvalid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: awvalid=%b want 1", awvalid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_send: aw/w/bready=%b want 000", {awvalid, wvalid, bready});
        end
        run_write(32'h1FD0_0204, 2'd2, 4'hF, 32'h1357_9BDF, 1, 0, 1, EXP_AWID, 2'b00);
    endtask

    task automatic test_spurious_bvalid();
        bvalid = 1'b1; bid = EXP_AWID; bresp = 2'b00;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (wr_data_ok !== 1'b0 || bready !== 1'b0 || awvalid !== 1'b0) begin
                errors++;
                $display("FAIL spurious_b: wr_data_ok=%b bready=%b awvalid=%b want 0 0 0",
                         wr_data_ok, bready, awvalid);
            end
            tick();
        end
        bvalid = 1'b0;
        run_write(32'h1FD0_0300, 2'd2, 4'hF, 32'h2468_ACE0, 0, 0, 0, EXP_AWID, 2'b00);
    endtask

    task automatic test_random();
        logic [1:0] sz;
        logic [3:0] b_id;
        for (int n = 0; n < 25; n++) begin
            sz   = 2'($urandom_range(0, 2));
            b_id = ($urandom_range(0, 3) == 0) ? 4'($urandom) : EXP_AWID;
            run_write($urandom, sz, 4'($urandom), $urandom,
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 3)), b_id, 2'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_split_handshake();
        test_back_to_back();
        test_byte_error();
        test_reset_mid_send();
        test_spurious_bvalid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
